bbox_overlay_mux: RTL and testbench
===================================

# bbox_overlay_mux

Parametrised bounding-box overlay stage between the moving-object detector and the video output path. Takes the RGB565 camera stream plus up to `OBJ_NUM` detector boxes, latches the box list once per frame, and draws each valid box with configurable line width, colour mode and optional interior tint. Outputs RGB565/RGB888 pixels with aligned sync, plus a per-frame object count.

## Interface
- `H_PIXEL`, 1024: active pixels per line.
- `V_PIXEL`, 768: active lines per frame.
- `OBJ_NUM`, 16: box slots, 1..32.
- `LINE_W`, 2: border thickness in pixels, 1..8.
- `MARGIN_X`, 20: horizontal guard band; no drawing where x < MARGIN_X or x ≥ H_PIXEL−MARGIN_X.
- `MARGIN_Y`, 20: vertical guard band, same rule on y.
- `sys_clk` in 1: pixel clock.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `pre_wr_en` in 1: input pixel valid.
- `pre_hs` in 1: input hsync.
- `pre_vs` in 1: input vsync, active high.
- `pos_data` in [42:0] × OBJ_NUM
  - [42] valid
  - [41:32] ymax
  - [31:21] xmax
  - [20:11] ymin
  - [10:0] xmin
- `cam_data` in 16: RGB565 pixel.
- `mode` in 2:
  - 00 pass-through
  - 01 red boxes
  - 10 palette boxes
  - 11 palette boxes + interior tint
- `fusion_rgb565` out 16: output pixel.
- `fusion_rgb888` out 24: output pixel.
- `fusion_hs`, `fusion_vs`, `fusion_wr_en` out 1: sync delayed 2 cycles.
- `obj_num` out 8: count of valid boxes in the current shadow list.
- `frame_latch` out 1: one-cycle pulse when the shadow list is updated.

## Operation
- **Frame latch**
  - Rising edge of `pre_vs` is detected against a registered copy.
  - On that edge: `pos_data` and `mode` are copied into shadow registers, `cnt_x`/`cnt_y` are cleared, and `frame_latch` pulses.
  - Drawing uses only shadow values, so there is no mid-frame tearing.
- **Position counters**
  - Advance only on `pre_wr_en`.
  - x wraps at H_PIXEL−1 and increments y; y wraps at V_PIXEL−1 back to 0.
  - A vsync edge has priority over a simultaneous increment.
- **Box validity**
  - A slot is drawn only if valid=1, xmin≤xmax and ymin≤ymax.
  - Malformed slots are ignored and not counted.
- **Border hit** for slot i, with the point inside the guard band:
  - Vertical edges: y∈[ymin,ymax] and (x∈[xmin, xmin+LINE_W−1] or x∈[xmax−LINE_W+1, xmax]).
  - Horizontal edges: x∈[xmin,xmax] and (y∈[ymin, ymin+LINE_W−1] or y∈[ymax−LINE_W+1, ymax]).
  - Edge arithmetic is 12-bit unsigned; subtraction underflow clamps to 0.
  - A box narrower than 2·LINE_W becomes fully border.
- **Interior hit**: strictly inside the box and not a border hit.
- **Priority**: the lowest index with a border hit wins. Any border hit beats any interior hit.
- **Colour**
  - Camera RGB888 is expanded by bit replication.
  - Mode 01: border pixel = FF0000.
  - Mode 10/11: palette[i mod 8] = FF0000, 00FF00, 0000FF, FFFF00, FF00FF, 00FFFF, FFFFFF, FF8000.
  - Mode 11 interior pixel: per-channel `(cam>>1)+(pal>>1)` of the lowest-index containing box.
  - Mode 00 and non-hit pixels: camera data unchanged.
- **Count**: `obj_num` is the popcount of valid, well-formed shadow slots. It updates on the cycle after `frame_latch` and holds until the next latch.

## Timing
- **Pipeline, 2 stages**
  - Stage 1: register border/interior hit vectors and delayed `cam_data`.
  - Stage 2: priority encode, select colour, register outputs.
- Pixel in at cycle n appears on `fusion_*` at cycle n+2. `fusion_hs`/`vs`/`wr_en` are delayed by exactly 2.
- Hit flags use counter values before that pixel's increment, so the first pixel after vsync is (0,0).
- `frame_latch` is asserted the cycle after the `pre_vs` rising edge. `obj_num` is valid one cycle later.
- **Reset values**: all outputs 0, counters 0, shadow list all invalid, shadow mode 00.
- **Reset mid-frame**: outputs are 0 immediately. Drawing is pass-through until the next vsync latch.
- `pos_data` or `mode` changing mid-frame has no effect until the next latch.
- Throughput is 1 pixel/cycle. `pre_wr_en` gaps stall counters only; the pipeline keeps flowing.

## Test plan
- Reset, then mode 01, slot 0 = {1, ymax 200, xmax 300, ymin 100, xmin 100}, LINE_W 2, grey input 0x8410:
  - (100..101, 150) and (299..300, 150) → FF0000.
  - (102,150) → 84/82/84.
  - `obj_num`=1.
- Mode 10, slots 3 and 11 overlapping at (400,400), both borders:
  - Output = palette[3] FFFF00, since the lower index wins.
  - Slot 11 alone elsewhere → FFFF00 (11 mod 8 = 3).
- Mode 11, slot 1 box, camera 0xFFFF:
  - Interior pixel → 7F+00, 7F+7F, 7F+00 = 7FFE7F.
  - Border pixel → 00FF00.
- Guard band: box with xmin 5, in mode 01 → no red at x<20. Malformed slot (xmin 500, xmax 400) → never drawn, `obj_num` excludes it.
- Mid-frame `pos_data` change at line 300:
  - Boxes unchanged until next `pre_vs`.
  - Then `frame_latch` pulses once and the new `obj_num` appears the following cycle.
- Latency/sync: random `pre_wr_en` gaps → `fusion_wr_en`/`hs`/`vs` match inputs delayed exactly 2 cycles. Counters wrap at (1023,767) → (0,0).

Source files
------------

// File: rtl/bbox_overlay_mux.sv
// rtl/bbox_overlay_mux.sv - bounding-box overlay on an RGB565 pixel stream
module bbox_overlay_mux #(
  parameter int H_PIXEL  = 1024,
  parameter int V_PIXEL  = 768,
  parameter int OBJ_NUM  = 16,
  parameter int LINE_W   = 2,
  parameter int MARGIN_X = 20,
  parameter int MARGIN_Y = 20
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     pre_wr_en,
  input  logic                     pre_hs,
  input  logic                     pre_vs,
  input  logic [OBJ_NUM-1:0][42:0] pos_data,
  input  logic [15:0]              cam_data,
  input  logic [1:0]               mode,
  output logic [15:0]              fusion_rgb565,
  output logic [23:0]              fusion_rgb888,
  output logic                     fusion_hs,
  output logic                     fusion_vs,
  output logic                     fusion_wr_en,
  output logic [7:0]               obj_num,
  output logic                     frame_latch
);

  // Edge and guard-band constants, all in the 12-bit edge arithmetic domain
  localparam logic [11:0] LW_M1 = 12'(LINE_W - 1);
  localparam logic [11:0] GX_LO = 12'(MARGIN_X);
  localparam logic [11:0] GX_HI = 12'(H_PIXEL - MARGIN_X);
  localparam logic [11:0] GY_LO = 12'(MARGIN_Y);
  localparam logic [11:0] GY_HI = 12'(V_PIXEL - MARGIN_Y);
  localparam logic [10:0] X_LAST = 11'(H_PIXEL - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_PIXEL - 1);

  // Frame latch state
  logic                     vs_q;
  logic                     vs_rise;
  logic [OBJ_NUM-1:0][42:0] shadow_pos;
  logic [1:0]               shadow_mode;
  logic [7:0]               valid_cnt;

  // Position counters
  logic [10:0] cnt_x;
  logic [9:0]  cnt_y;
  logic [11:0] px;
  logic [11:0] py;
  logic        in_guard;

  // Stage 1
  logic [OBJ_NUM-1:0] border_hit;
  logic [OBJ_NUM-1:0] inter_hit;
  logic [OBJ_NUM-1:0] border_s1;
  logic [OBJ_NUM-1:0] inter_s1;
  logic [15:0]        cam_s1;
  logic [1:0]         mode_s1;
  logic               hs_s1;
  logic               vs_s1;
  logic               wr_s1;

  // Stage 2 combinational
  logic        b_any;
  logic        i_any;
  logic [2:0]  b_pal;
  logic [2:0]  i_pal;
  logic [23:0] cam888;
  logic [23:0] tint_c;
  logic [23:0] pix;

  // A slot is usable only if flagged valid and its corners are ordered
  function automatic logic box_ok(input logic [42:0] box);
    return box[42] && (box[10:0] <= box[31:21]) && (box[20:11] <= box[41:32]);
  endfunction

  // Returns {border, interior} for one box at point (x, y); far edges clamp at 0
  function automatic logic [1:0] classify(input logic [42:0] box,
                                          input logic [11:0] x,
                                          input logic [11:0] y);
    logic [11:0] xmin, xmax, ymin, ymax;
    logic [11:0] xl_end, xr_beg, yt_end, yb_beg;
    logic        in_x, in_y, on_v, on_h, bord, inner;
    xmin   = {1'b0, box[10:0]};
    xmax   = {1'b0, box[31:21]};
    ymin   = {2'b0, box[20:11]};
    ymax   = {2'b0, box[41:32]};
    xl_end = xmin + LW_M1;
    yt_end = ymin + LW_M1;
    xr_beg = (xmax >= LW_M1) ? (xmax - LW_M1) : 12'd0;
    yb_beg = (ymax >= LW_M1) ? (ymax - LW_M1) : 12'd0;
    in_x   = (x >= xmin) && (x <= xmax);
    in_y   = (y >= ymin) && (y <= ymax);
    on_v   = in_y && (((x >= xmin) && (x <= xl_end)) || ((x >= xr_beg) && (x <= xmax)));
    on_h   = in_x && (((y >= ymin) && (y <= yt_end)) || ((y >= yb_beg) && (y <= ymax)));
    bord   = box_ok(box) && (on_v || on_h);
    inner  = box_ok(box) && !bord && (x > xmin) && (x < xmax) && (y > ymin) && (y < ymax);
    return {bord, inner};
  endfunction

  // Eight-entry box palette, indexed by slot number mod 8
  function automatic logic [23:0] palette(input logic [2:0] k);
    logic [23:0] c;
    case (k)
      3'd0:    c = 24'hFF0000;
      3'd1:    c = 24'h00FF00;
      3'd2:    c = 24'h0000FF;
      3'd3:    c = 24'hFFFF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'h00FFFF;
      3'd6:    c = 24'hFFFFFF;
      default: c = 24'hFF8000;
    endcase
    return c;
  endfunction

  assign vs_rise = pre_vs && !vs_q;

  // Vsync edge detect; box list and mode are frozen here for the whole frame
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_q        <= 1'b0;
      frame_latch <= 1'b0;
      shadow_pos  <= '0;
      shadow_mode <= 2'b00;
    end else begin
      vs_q        <= pre_vs;
      frame_latch <= vs_rise;
      if (vs_rise) begin
        shadow_pos  <= pos_data;
        shadow_mode <= mode;
      end
    end
  end

  // Count of drawable slots in the shadow list
  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < OBJ_NUM; i++) begin
      valid_cnt = valid_cnt + 8'(box_ok(shadow_pos[i]));
    end
  end

  // Object count follows the latch by one cycle, once the shadow list is settled
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      obj_num <= 8'd0;
    end else if (frame_latch) begin
      obj_num <= valid_cnt;
    end
  end

  // Raster position; vsync clear wins over a coincident pixel
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_x <= '0;
      cnt_y <= '0;
    end else if (vs_rise) begin
      cnt_x <= '0;
      cnt_y <= '0;
    end else if (pre_wr_en) begin
      if (cnt_x == X_LAST) begin
        cnt_x <= '0;
        cnt_y <= (cnt_y == Y_LAST) ? 10'd0 : cnt_y + 10'd1;
      end else begin
        cnt_x <= cnt_x + 11'd1;
      end
    end
  end

  // Per-slot border/interior hits for the current pixel, masked by the guard band
  always_comb begin
    px       = {1'b0, cnt_x};
    py       = {2'b0, cnt_y};
    in_guard = (px >= GX_LO) && (px < GX_HI) && (py >= GY_LO) && (py < GY_HI);
    border_hit = '0;
    inter_hit  = '0;
    for (int i = 0; i < OBJ_NUM; i++) begin
      {border_hit[i], inter_hit[i]} = classify(shadow_pos[i], px, py) & {2{in_guard}};
    end
  end

  // Stage 1 register: hit vectors plus camera pixel and sync delayed alongside
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      border_s1 <= '0;
      inter_s1  <= '0;
      cam_s1    <= '0;
      mode_s1   <= 2'b00;
      hs_s1     <= 1'b0;
      vs_s1     <= 1'b0;
      wr_s1     <= 1'b0;
    end else begin
      border_s1 <= border_hit;
      inter_s1  <= inter_hit;
      cam_s1    <= cam_data;
      mode_s1   <= shadow_mode;
      hs_s1     <= pre_hs;
      vs_s1     <= pre_vs;
      wr_s1     <= pre_wr_en;
    end
  end

  // Lowest-index priority encode of border and interior hits
  always_comb begin
    b_any = |border_s1;
    i_any = |inter_s1;
    b_pal = 3'd0;
    i_pal = 3'd0;
    for (int i = OBJ_NUM - 1; i >= 0; i--) begin
      if (border_s1[i]) b_pal = 3'(i);
      if (inter_s1[i])  i_pal = 3'(i);
    end
  end

  // Colour select: borders beat interiors, interior tint only in mode 11
  always_comb begin
    cam888 = {cam_s1[15:11], cam_s1[15:13], cam_s1[10:5], cam_s1[10:9], cam_s1[4:0], cam_s1[4:2]};
    tint_c = palette(i_pal);
    pix    = cam888;
    case (mode_s1)
      2'b01: if (b_any) pix = 24'hFF0000;
      2'b10: if (b_any) pix = palette(b_pal);
      2'b11: begin
        if (b_any) begin
          pix = palette(b_pal);
        end else if (i_any) begin
          pix[23:16] = {1'b0, cam888[23:17]} + {1'b0, tint_c[23:17]};
          pix[15:8]  = {1'b0, cam888[15:9]}  + {1'b0, tint_c[15:9]};
          pix[7:0]   = {1'b0, cam888[7:1]}   + {1'b0, tint_c[7:1]};
        end
      end
      default: ;
    endcase
  end

  // Stage 2 register: final pixel and sync, two cycles after the input
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fusion_rgb888 <= '0;
      fusion_rgb565 <= '0;
      fusion_hs     <= 1'b0;
      fusion_vs     <= 1'b0;
      fusion_wr_en  <= 1'b0;
    end else begin
      fusion_rgb888 <= pix;
      fusion_rgb565 <= {pix[23:19], pix[15:10], pix[7:3]};
      fusion_hs     <= hs_s1;
      fusion_vs     <= vs_s1;
      fusion_wr_en  <= wr_s1;
    end
  end

endmodule

// File: tb/tb_bbox_overlay_mux.sv
// tb/tb_bbox_overlay_mux.sv - scoreboard bench for bbox_overlay_mux
`timescale 1ns/1ps
module tb_bbox_overlay_mux;

  localparam int H  = 96;
  localparam int V  = 48;
  localparam int NO = 16;
  localparam logic [23:0] G888 = 24'h848284;
  localparam logic [15:0] G565 = 16'h8410;

  logic                sys_clk = 1'b0;
  logic                sys_rst_n;
  logic                pre_wr_en, pre_hs, pre_vs;
  logic [NO-1:0][42:0] pos_data;
  logic [15:0]         cam_data;
  logic [1:0]          mode;
  logic [15:0]         fusion_rgb565;
  logic [23:0]         fusion_rgb888;
  logic                fusion_hs, fusion_vs, fusion_wr_en;
  logic [7:0]          obj_num;
  logic                frame_latch;

  bbox_overlay_mux #(
    .H_PIXEL(H), .V_PIXEL(V), .OBJ_NUM(NO), .LINE_W(2), .MARGIN_X(8), .MARGIN_Y(8)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pre_wr_en(pre_wr_en), .pre_hs(pre_hs),
    .pre_vs(pre_vs), .pos_data(pos_data), .cam_data(cam_data), .mode(mode),
    .fusion_rgb565(fusion_rgb565), .fusion_rgb888(fusion_rgb888), .fusion_hs(fusion_hs),
    .fusion_vs(fusion_vs), .fusion_wr_en(fusion_wr_en), .obj_num(obj_num),
    .frame_latch(frame_latch)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { int x; int y; logic [23:0] e888; logic [15:0] e565; } plan_t;
  typedef struct { int seq; int x; int y; logic [23:0] e888; logic [15:0] e565; } sb_t;

  plan_t plan[$];
  sb_t   sb[$];
  int    checks = 0;
  int    errors = 0;
  int    in_seq = 0;
  int    out_seq = 0;
  int    sync_bad = 0;
  int    hist_n = 0;
  int    cur_obj = 0;
  int    chg_line = -1;
  logic [NO-1:0][42:0] chg_pos;
  logic [1:0]          chg_mode;
  logic [15:0]         cam_val;
  logic [2:0]          h1, h2;

  function automatic logic [42:0] mk_box(input int xmin, input int ymin, input int xmax, input int ymax);
    logic [42:0] b;
    b = {1'b1, 10'(ymax), 11'(xmax), 10'(ymin), 11'(xmin)};
    return b;
  endfunction

  task automatic add(input int x, input int y, input logic [23:0] e888, input logic [15:0] e565);
    plan_t p;
    p.x = x; p.y = y; p.e888 = e888; p.e565 = e565;
    plan.push_back(p);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic sync_check();
    checks++;
    if (sync_bad != 0) begin
      errors++;
      $display("FAIL sync_delay2: %0d mismatching cycles, expected 0", sync_bad);
    end
    sync_bad = 0;
  endtask

  // Pixel monitor: pops an expectation whenever the tagged output pixel appears
  always @(negedge sys_clk) begin
    sb_t e;
    if (!sys_rst_n) begin
      out_seq = 0;
    end else if (fusion_wr_en) begin
      if (sb.size() > 0 && sb[0].seq == out_seq) begin
        e = sb.pop_front();
        checks++;
        if (fusion_rgb888 !== e.e888 || fusion_rgb565 !== e.e565) begin
          errors++;
          $display("FAIL pix(%0d,%0d): got %h/%h expected %h/%h",
                   e.x, e.y, fusion_rgb888, fusion_rgb565, e.e888, e.e565);
        end
      end
      out_seq++;
    end
  end

  // Sync monitor: outputs must equal the inputs seen two cycles earlier
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      hist_n = 0;
    end else begin
      if (hist_n >= 2 && {fusion_wr_en, fusion_hs, fusion_vs} !== h2) sync_bad++;
      h2 = h1;
      h1 = {pre_wr_en, pre_hs, pre_vs};
      hist_n++;
    end
  end

  task automatic vsync(input int exp_obj);
    pre_vs = 1'b1; pre_wr_en = 1'b0; pre_hs = 1'b0;
    @(negedge sys_clk); chk("latch_before", frame_latch, 0);
    @(negedge sys_clk); chk("latch_pulse", frame_latch, 1); chk("obj_hold", obj_num, cur_obj);
    @(negedge sys_clk); chk("latch_end", frame_latch, 0);   chk("obj_new", obj_num, exp_obj);
    @(negedge sys_clk); chk("latch_once", frame_latch, 0);
    step();
    pre_vs = 1'b0;
    step(); step();
    cur_obj = exp_obj;
  endtask

  task automatic run_frame(input int nlines, input bit gaps);
    sb_t e;
    for (int y = 0; y < nlines; y++) begin
      if (y == chg_line) begin pos_data = chg_pos; mode = chg_mode; end
      for (int x = 0; x < H; x++) begin
        if (gaps) begin
          while ($urandom_range(0, 3) == 0) begin pre_wr_en = 1'b0; step(); end
        end
        pre_wr_en = 1'b1; pre_hs = 1'b1; cam_data = cam_val;
        foreach (plan[k]) begin
          if (plan[k].x == x && plan[k].y == y) begin
            e.seq = in_seq; e.x = x; e.y = y; e.e888 = plan[k].e888; e.e565 = plan[k].e565;
            sb.push_back(e);
          end
        end
        in_seq++;
        step();
      end
      pre_wr_en = 1'b0; pre_hs = 1'b0;
      step();
    end
    chg_line = -1;
    step(); step();
    sync_check();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst_n = 1'b0;
    pre_wr_en = 1'b1; pre_hs = 1'b1; pre_vs = 1'b0;
    cam_data = 16'hFFFF; mode = 2'b01;
    pos_data = '0; pos_data[0] = mk_box(20, 10, 50, 30);
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_rgb565", fusion_rgb565, 0);
    chk("rst_rgb888", fusion_rgb888, 0);
    chk("rst_sync", {fusion_wr_en, fusion_hs, fusion_vs}, 0);
    chk("rst_obj_num", obj_num, 0);
    chk("rst_latch", frame_latch, 0);
    pre_wr_en = 1'b0; pre_hs = 1'b0;
    step();
    sys_rst_n = 1'b1;
    step(); step();

    // Mode 01: red borders, guard band, malformed slot
    cam_val = 16'h8410; mode = 2'b01; pos_data = '0;
    pos_data[0] = mk_box(20, 10, 50, 30);
    pos_data[1] = mk_box(2, 12, 15, 20);
    pos_data[2] = mk_box(70, 10, 60, 30);
    pos_data[3] = mk_box(60, 36, 70, 45);
    vsync(3);
    plan.delete();
    add(20, 20, 24'hFF0000, 16'hF800); add(21, 20, 24'hFF0000, 16'hF800);
    add(22, 20, G888, G565);           add(48, 20, G888, G565);
    add(49, 20, 24'hFF0000, 16'hF800); add(50, 20, 24'hFF0000, 16'hF800);
    add(19, 20, G888, G565);           add(51, 20, G888, G565);
    add(30, 10, 24'hFF0000, 16'hF800); add(30, 11, 24'hFF0000, 16'hF800);
    add(30, 12, G888, G565);
    add(2, 15, G888, G565);            add(7, 12, G888, G565);
    add(8, 12, 24'hFF0000, 16'hF800);  add(14, 15, 24'hFF0000, 16'hF800);
    add(15, 15, 24'hFF0000, 16'hF800); add(13, 15, G888, G565);
    add(60, 10, G888, G565);           add(70, 20, G888, G565);
    add(65, 10, G888, G565);
    add(65, 36, 24'hFF0000, 16'hF800); add(65, 37, 24'hFF0000, 16'hF800);
    add(65, 38, G888, G565);           add(60, 39, 24'hFF0000, 16'hF800);
    add(60, 40, G888, G565);           add(70, 39, 24'hFF0000, 16'hF800);
    run_frame(41, 1'b0);

    // Mode 10: palette, overlap priority, index mod 8
    cam_val = 16'h0000; mode = 2'b10; pos_data = '0;
    pos_data[3]  = mk_box(30, 15, 60, 35);
    pos_data[11] = mk_box(59, 20, 80, 28);
    pos_data[5]  = mk_box(10, 30, 20, 38);
    vsync(3);
    plan.delete();
    add(59, 24, 24'hFFFF00, 16'hFFE0); add(80, 24, 24'hFFFF00, 16'hFFE0);
    add(70, 20, 24'hFFFF00, 16'hFFE0); add(30, 15, 24'hFFFF00, 16'hFFE0);
    add(10, 34, 24'h00FFFF, 16'h07FF); add(15, 34, 24'h000000, 16'h0000);
    add(45, 25, 24'h000000, 16'h0000);
    run_frame(36, 1'b0);

    // Mode 11: interior tint, border beats interior
    cam_val = 16'hFFFF; mode = 2'b11; pos_data = '0;
    pos_data[1] = mk_box(20, 10, 40, 30);
    pos_data[0] = mk_box(30, 5, 60, 38);
    vsync(2);
    plan.delete();
    add(25, 20, 24'h7FFE7F, 16'h7FEF); add(35, 20, 24'hFE7F7F, 16'hFBEF);
    add(30, 20, 24'hFF0000, 16'hF800); add(40, 20, 24'h00FF00, 16'h07E0);
    add(20, 20, 24'h00FF00, 16'h07E0); add(50, 20, 24'hFE7F7F, 16'hFBEF);
    add(70, 20, 24'hFFFFFF, 16'hFFFF); add(25, 10, 24'h00FF00, 16'h07E0);
    run_frame(21, 1'b0);

    // Mid-frame pos_data/mode change takes effect only at the next latch
    cam_val = 16'h8410; mode = 2'b01; pos_data = '0;
    pos_data[0] = mk_box(20, 10, 50, 30);
    vsync(1);
    chg_pos = '0;
    chg_pos[0] = mk_box(60, 12, 80, 36);
    chg_pos[4] = mk_box(10, 10, 15, 15);
    chg_mode = 2'b10;
    chg_line = 24;
    plan.delete();
    add(20, 20, 24'hFF0000, 16'hF800); add(20, 28, 24'hFF0000, 16'hF800);
    add(30, 30, 24'hFF0000, 16'hF800); add(60, 30, G888, G565);
    add(70, 12, G888, G565);
    run_frame(V, 1'b0);
    vsync(2);
    plan.delete();
    add(10, 12, 24'hFF00FF, 16'hF81F); add(20, 28, G888, G565);
    add(60, 30, 24'hFF0000, 16'hF800); add(70, 12, 24'hFF0000, 16'hF800);
    add(70, 20, G888, G565);
    run_frame(36, 1'b0);

    // Random wr_en gaps, full frame then continue past the wrap without vsync
    mode = 2'b01; pos_data = '0;
    pos_data[0] = mk_box(20, 10, 50, 30);
    vsync(1);
    plan.delete();
    add(20, 20, 24'hFF0000, 16'hF800); add(22, 20, G888, G565);
    add(30, 10, 24'hFF0000, 16'hF800); add(50, 30, 24'hFF0000, 16'hF800);
    run_frame(V, 1'b1);
    run_frame(31, 1'b1);

    // Reset in the middle of a frame clears outputs and the shadow list
    vsync(1);
    plan.delete();
    add(30, 10, 24'hFF0000, 16'hF800); add(20, 11, 24'hFF0000, 16'hF800);
    run_frame(12, 1'b0);
    pre_wr_en = 1'b1; pre_hs = 1'b1;
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_rgb888", fusion_rgb888, 0);
    chk("midrst_rgb565", fusion_rgb565, 0);
    chk("midrst_sync", {fusion_wr_en, fusion_hs, fusion_vs}, 0);
    chk("midrst_obj_num", obj_num, 0);
    sb.delete();
    in_seq = 0;
    pre_wr_en = 1'b0; pre_hs = 1'b0;
    step(); step();
    sys_rst_n = 1'b1;
    step();
    plan.delete();
    add(20, 20, G888, G565); add(30, 10, G888, G565); add(50, 15, G888, G565);
    run_frame(24, 1'b0);
    chk("post_rst_obj_num", obj_num, 0);

    repeat (5) step();
    chk("scoreboard_empty", sb.size(), 0);
    sync_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
